quiz_engine: RTL and testbench

Parametrised game engine for the decimal-to-binary panorama quiz. It replaces the fixed 4-digit, 14-bit, single-rate game core with one configurable for digit count, answer width, clock rate, time limit and wrong-answer penalty. It converts the loaded digits to binary sequentially, runs a seconds countdown, and drives the flash, hint, score and best-score outputs. It sits between the board top level (switches, keys, hex decoders) and the LED and hex outputs.

---
 rtl/quiz_engine.sv | 234 +++++++++++++++++++++++
 tb/tb_quiz_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/quiz_engine.sv
// Decimal-to-binary quiz game core: digit entry, sequential BCD conversion,
// seconds countdown with penalties, flash/hint outputs and streak scoring.
module quiz_engine #(
    parameter int DIGITS       = 4,
    parameter int BITS         = 14,
    parameter int CLK_HZ       = 50000000,
    parameter int TIME_LIMIT_S = 30,
    parameter int PENALTY_S    = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                next,
    input  logic                go,
    input  logic                check,
    input  logic [9:0]          sw_digit,
    input  logic [BITS-1:0]     sw_answer,
    input  logic                hint,
    output logic [4*DIGITS-1:0] digits,
    output logic [BITS-1:0]     target,
    output logic [6:0]          time_left,
    output logic [6:0]          score,
    output logic [6:0]          best,
    output logic                flash,
    output logic [BITS-1:0]     hint_mask,
    output logic                win,
    output logic                lose,
    output logic                err
);
    localparam int DW = 4 * DIGITS;
    localparam int AW = BITS + 4;
    localparam int SW = AW + 4;
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int H2 = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
    localparam int H4 = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int H8 = (CLK_HZ / 8 > 0) ? CLK_HZ / 8 : 1;
    localparam logic [SW-1:0] LIMIT = SW'(1) << BITS;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_PLAY, S_RESULT} state_t;

    state_t          state_q, state_d;
    logic            next_q, go_q, check_q;
    logic [DW-1:0]   digits_q, digits_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            ovf_q, ovf_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [BITS-1:0] target_q, target_d;
    logic [6:0]      time_left_q, time_left_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [PW-1:0]   fcnt_q, fcnt_d;
    logic            flash_q, flash_d;
    logic [6:0]      score_q, score_d;
    logic [6:0]      best_q, best_d;
    logic            win_q, win_d;
    logic            lose_q, lose_d;
    logic            err_q, err_d;

    logic            next_edge, go_edge, check_edge;
    logic [3:0]      dig_val;
    logic            dig_ok;
    logic [DW-1:0]   dig_ext;
    logic [3:0]      cur_digit;
    logic [SW-1:0]   step_w;
    logic            tick, correct, wrong;
    int              tl_int;
    logic [6:0]      tl_new;
    logic [6:0]      score_inc;
    logic [PW-1:0]   h_m1;

    assign next_edge  = next & ~next_q;
    assign go_edge    = go & ~go_q;
    assign check_edge = check & ~check_q;

    always_comb begin
        dig_val = '0;
        dig_ok  = $onehot(sw_digit);
        for (int unsigned i = 0; i < 10; i++) begin
            if (sw_digit[i]) dig_val = 4'(i);
        end
        dig_ext      = '0;
        dig_ext[3:0] = dig_val;
    end

    always_comb begin
        cur_digit = digits_q[int'(idx_q)*4 +: 4];
        step_w    = SW'(acc_q) * SW'(10) + SW'(cur_digit);
        tick      = (presc_q == PW'(CLK_HZ - 1));
        correct   = check_edge && (sw_answer == target_q);
        wrong     = check_edge && !correct;
        // A tick and a wrong check in the same cycle both come off the clock.
        tl_int    = int'(time_left_q) - (tick ? 1 : 0) - (wrong ? PENALTY_S : 0);
        tl_new    = (tl_int > 0) ? 7'(tl_int) : 7'd0;
        score_inc = (score_q >= 7'd99) ? 7'd99 : score_q + 7'd1;
        if (time_left_q >= 7'd10)     h_m1 = PW'(H2 - 1);
        else if (time_left_q >= 7'd5) h_m1 = PW'(H4 - 1);
        else                          h_m1 = PW'(H8 - 1);
    end

    always_comb begin
        state_d     = state_q;
        digits_d    = digits_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        idx_d       = idx_q;
        target_d    = target_q;
        time_left_d = time_left_q;
        presc_d     = presc_q;
        fcnt_d      = fcnt_q;
        flash_d     = 1'b0;
        score_d     = score_q;
        best_d      = best_q;
        win_d       = win_q;
        lose_d      = lose_q;
        err_d       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (next_edge && dig_ok) digits_d = (digits_q << 4) | dig_ext;
                if (go_edge) begin
                    state_d = S_CONVERT;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    idx_d   = IW'(DIGITS - 1);
                end
            end
            S_CONVERT: begin
                // Overflow is sticky so truncation of acc never hides it.
                acc_d = step_w[AW-1:0];
                ovf_d = ovf_q | (step_w >= LIMIT);
                idx_d = idx_q - IW'(1);
                if (idx_q == '0) begin
                    if (ovf_q || (step_w >= LIMIT)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        target_d    = step_w[BITS-1:0];
                        time_left_d = 7'(TIME_LIMIT_S);
                        presc_d     = '0;
                        fcnt_d      = '0;
                        state_d     = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (fcnt_q >= h_m1) begin
                    fcnt_d  = '0;
                    flash_d = ~flash_q;
                end else begin
                    fcnt_d  = fcnt_q + PW'(1);
                    flash_d = flash_q;
                end
                if (correct) begin
                    win_d   = 1'b1;
                    score_d = score_inc;
                    best_d  = (score_inc > best_q) ? score_inc : best_q;
                    flash_d = 1'b0;
                    state_d = S_RESULT;
                end else begin
                    time_left_d = tl_new;
                    if (tl_new == 7'd0) begin
                        lose_d  = 1'b1;
                        score_d = '0;
                        flash_d = 1'b0;
                        state_d = S_RESULT;
                    end
                end
            end
            S_RESULT: begin
                if (go_edge) begin
                    digits_d = '0;
                    target_d = '0;
                    win_d    = 1'b0;
                    lose_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            next_q      <= 1'b0;
            go_q        <= 1'b0;
            check_q     <= 1'b0;
            digits_q    <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            idx_q       <= '0;
            target_q    <= '0;
            time_left_q <= '0;
            presc_q     <= '0;
            fcnt_q      <= '0;
            flash_q     <= 1'b0;
            score_q     <= '0;
            best_q      <= '0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_q      <= next;
            go_q        <= go;
            check_q     <= check;
            digits_q    <= digits_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            idx_q       <= idx_d;
            target_q    <= target_d;
            time_left_q <= time_left_d;
            presc_q     <= presc_d;
            fcnt_q      <= fcnt_d;
            flash_q     <= flash_d;
            score_q     <= score_d;
            best_q      <= best_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            err_q       <= err_d;
        end
    end

    assign digits    = digits_q;
    assign target    = target_q;
    assign time_left = time_left_q;
    assign score     = score_q;
    assign best      = best_q;
    assign flash     = flash_q;
    assign win       = win_q;
    assign lose      = lose_q;
    assign err       = err_q;
    assign hint_mask = (state_q == S_PLAY && hint) ? (sw_answer ^ target_q) : '0;

endmodule

// File: tb/tb_quiz_engine.sv
// Directed bench for quiz_engine: a 14-bit instance for gameplay and a 13-bit
// instance driven in parallel for the conversion-overflow case.
module tb_quiz_engine;
    logic        clk = 1'b0;
    logic        resetn, next, go, check, hint_sw;
    logic [9:0]  sw_digit;
    logic [13:0] sw_answer;

    logic [15:0] digits, digits13;
    logic [13:0] target, hint_mask;
    logic [12:0] target13, hint_mask13;
    logic [6:0]  time_left, score, best, time_left13, score13, best13;
    logic        flash, win, lose, err, flash13, win13, lose13, err13;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    quiz_engine #(.DIGITS(4), .BITS(14), .CLK_HZ(8), .TIME_LIMIT_S(5), .PENALTY_S(2)) dut (
        .clk(clk), .resetn(resetn), .next(next), .go(go), .check(check),
        .sw_digit(sw_digit), .sw_answer(sw_answer), .hint(hint_sw),
        .digits(digits), .target(target), .time_left(time_left), .score(score),
        .best(best), .flash(flash), .hint_mask(hint_mask), .win(win), .lose(lose),
        .err(err)
    );

    quiz_engine #(.DIGITS(4), .BITS(13), .CLK_HZ(8), .TIME_LIMIT_S(5), .PENALTY_S(2)) dut13 (
        .clk(clk), .resetn(resetn), .next(next), .go(go), .check(check),
        .sw_digit(sw_digit), .sw_answer(sw_answer[12:0]), .hint(hint_sw),
        .digits(digits13), .target(target13), .time_left(time_left13), .score(score13),
        .best(best13), .flash(flash13), .hint_mask(hint_mask13), .win(win13),
        .lose(lose13), .err(err13)
    );

    typedef struct {
        logic [9:0]  sel;
        logic [15:0] exp_digits;
    } entry_t;

    entry_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_next(input logic [9:0] sel);
        sw_digit = sel;
        next = 1'b1;
        cyc(1);
        next = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        cyc(1);
    endtask

    task automatic load4(input int d3, input int d2, input int d1, input int d0);
        pulse_next(10'(1 << d3));
        pulse_next(10'(1 << d2));
        pulse_next(10'(1 << d1));
        pulse_next(10'(1 << d0));
    endtask

    // Returns with the go edge plus four CONVERT edges consumed.
    task automatic start_round();
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        cyc(4);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_digits"}, int'(digits), 0);
        chk({tag, "_target"}, int'(target), 0);
        chk({tag, "_time_left"}, int'(time_left), 0);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_best"}, int'(best), 0);
        chk({tag, "_flash"}, int'(flash), 0);
        chk({tag, "_hint_mask"}, int'(hint_mask), 0);
        chk({tag, "_win"}, int'(win), 0);
        chk({tag, "_lose"}, int'(lose), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        tbl[0] = '{10'h002, 16'h0001};
        tbl[1] = '{10'h004, 16'h0012};
        tbl[2] = '{10'h003, 16'h0012};
        tbl[3] = '{10'h000, 16'h0012};
        tbl[4] = '{10'h008, 16'h0123};
        tbl[5] = '{10'h010, 16'h1234};

        resetn = 1'b0; next = 1'b0; go = 1'b0; check = 1'b0; hint_sw = 1'b0;
        sw_digit = '0; sw_answer = '0;
        cyc(2);
        resetn = 1'b1;
        cyc(1);
        chk_reset("reset");

        for (int i = 0; i < 6; i++) begin
            pulse_next(tbl[i].sel);
            chk($sformatf("entry%0d_digits", i), int'(digits), int'(tbl[i].exp_digits));
        end

        // Conversion latency: target appears only after the fourth CONVERT edge.
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        cyc(3);
        chk("convert_early_target", int'(target), 0);
        cyc(1);
        chk("convert_target", int'(target), 16'h04D2);
        chk("convert_time_left", int'(time_left), 5);

        sw_answer = 14'd1230;
        check = 1'b1;
        cyc(1);
        chk("wrong_check_time_left", int'(time_left), 3);
        check = 1'b0;
        cyc(1);
        sw_answer = 14'd1235;
        hint_sw = 1'b1;
        #1;
        chk("hint_on_mask", int'(hint_mask), 1);
        hint_sw = 1'b0;
        #1;
        chk("hint_off_mask", int'(hint_mask), 0);
        sw_answer = 14'd1234;
        check = 1'b1;
        cyc(1);
        check = 1'b0;
        chk("win_lamp", int'(win), 1);
        chk("win_lose_lamp", int'(lose), 0);
        chk("win_score", int'(score), 1);
        chk("win_best", int'(best), 1);
        chk("win_flash_off", int'(flash), 0);

        pulse_go();
        chk("leave_digits", int'(digits), 0);
        chk("leave_target", int'(target), 0);
        chk("leave_win", int'(win), 0);
        chk("leave_score", int'(score), 1);

        load4(1, 2, 3, 4);
        start_round();
        chk("timeout_flash_p0", int'(flash), 0);
        cyc(1);
        chk("timeout_flash_p1", int'(flash), 0);
        cyc(1);
        chk("timeout_flash_p2", int'(flash), 1);
        cyc(5);
        chk("timeout_tl_p7", int'(time_left), 5);
        cyc(1);
        chk("timeout_tl_p8", int'(time_left), 4);
        for (int n = 2; n <= 5; n++) begin
            cyc(8);
            chk($sformatf("timeout_tl_step%0d", n), int'(time_left), 5 - n);
        end
        chk("timeout_lose", int'(lose), 1);
        chk("timeout_win", int'(win), 0);
        chk("timeout_score", int'(score), 0);
        chk("timeout_best", int'(best), 1);

        pulse_go();
        load4(9, 9, 9, 9);
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        cyc(3);
        chk("ovf_err_early", int'(err13), 0);
        cyc(1);
        chk("ovf_err_pulse", int'(err13), 1);
        chk("fit_err", int'(err), 0);
        chk("fit_target", int'(target), 9999);
        cyc(1);
        chk("ovf_err_clear", int'(err13), 0);
        chk("ovf_digits", int'(digits13), 16'h9999);
        chk("ovf_target", int'(target13), 0);
        pulse_next(10'h003);
        chk("ovf_invalid_digit", int'(digits13), 16'h9999);
        pulse_next(10'h020);
        chk("ovf_idle_shift", int'(digits13), 16'h9995);
        chk("play_ignores_next", int'(digits), 16'h9999);

        resetn = 1'b0;
        cyc(1);
        resetn = 1'b1;
        chk_reset("midplay_reset");

        load4(1, 2, 3, 4);
        start_round();
        cyc(7);
        sw_answer = 14'd1230;
        check = 1'b1;
        cyc(1);
        check = 1'b0;
        chk("wrong_plus_tick_tl", int'(time_left), 2);
        cyc(8);
        chk("after_penalty_tick_tl", int'(time_left), 1);
        cyc(7);
        sw_answer = 14'd1234;
        check = 1'b1;
        cyc(1);
        check = 1'b0;
        chk("last_tick_win", int'(win), 1);
        chk("last_tick_lose", int'(lose), 0);
        chk("last_tick_score", int'(score), 1);
        chk("last_tick_best", int'(best), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
